// File: rtl/message_byte_loader_if.sv
// -----------------------------------------------------------------------------
// message_byte_loader_if
//   Groups the byte-stream handshake and the assembled-message outputs of the
//   message byte loader.
//
//   slave  : loader side (consumes bytes and produces the message)
//   master : source/consumer side (drives bytes and acknowledges the message)
//
//   start      one-cycle pulse, begins a new message
//   in_valid   in_data is valid
//   in_data    character byte
//   in_last    final byte of the message (qualified by in_valid)
//   in_ready   loader accepts a byte this cycle
//   message    assembled message, bits [8:1] hold the newest byte
//   msg_valid  message complete and stable
//   msg_ack    consumer has taken the message
//   byte_count bytes accepted into the current message
//   truncated  message ended only because capacity was reached
// -----------------------------------------------------------------------------
interface message_byte_loader_if #(
  parameter int MSG_BYTES = 100,
  parameter int CNT_W     = 7
);
  logic                   start;
  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   in_last;
  logic                   in_ready;
  logic [8*MSG_BYTES:1]   message;
  logic                   msg_valid;
  logic                   msg_ack;
  logic [CNT_W-1:0]       byte_count;
  logic                   truncated;

  modport slave (
    input  start, in_valid, in_data, in_last, msg_ack,
    output in_ready, message, msg_valid, byte_count, truncated
  );

  modport master (
    output start, in_valid, in_data, in_last, msg_ack,
    input  in_ready, message, msg_valid, byte_count, truncated
  );
endinterface

// File: rtl/message_byte_loader.sv
// -----------------------------------------------------------------------------
// message_byte_loader
//   Packs a byte stream into a wide, right-justified message word. Each
//   accepted byte shifts in at the LSB end; unused leading bytes stay zero and
//   the terminator byte is kept in the word.
//
//   Ports:
//     clock    system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      message_byte_loader_if.slave (byte handshake + message outputs)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; message from the last run is still held
//   LOAD  | in_ready high, accepting bytes until terminator/last/capacity
//   DONE  | msg_valid high, message frozen until msg_ack
// -----------------------------------------------------------------------------
module message_byte_loader #(
  parameter int         MSG_BYTES = 100,
  parameter logic [7:0] TERM_CHAR = 8'h0A,
  parameter int         CNT_W     = 7
) (
  input  logic                  clock,
  input  logic                  reset_n,
  message_byte_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [8*MSG_BYTES:1]   r_message;
  logic [CNT_W-1:0]       r_byte_count;
  logic                   r_in_ready;
  logic                   r_msg_valid;
  logic                   r_truncated;

  logic                   w_accept;
  logic [CNT_W-1:0]       w_count_nxt;
  logic                   w_is_term;
  logic                   w_at_cap;
  logic                   w_end;

  // r_in_ready mirrors state==LOAD, so it doubles as the LOAD qualifier here.
  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_count_nxt = r_byte_count + CNT_W'(1);
  assign w_is_term   = (bus.in_data == TERM_CHAR);
  assign w_at_cap    = (w_count_nxt == CNT_W'(MSG_BYTES));
  assign w_end       = w_is_term || bus.in_last || w_at_cap;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_message    <= '0;
      r_byte_count <= '0;
      r_in_ready   <= 1'b0;
      r_msg_valid  <= 1'b0;
      r_truncated  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state      <= S_LOAD;
            r_message    <= '0;
            r_byte_count <= '0;
            r_truncated  <= 1'b0;
            r_in_ready   <= 1'b1;
          end
        end

        S_LOAD: begin
          // A restart wins over a same-cycle accept; that byte is dropped.
          if (bus.start) begin
            r_message    <= '0;
            r_byte_count <= '0;
            r_truncated  <= 1'b0;
          end else if (w_accept) begin
            r_message    <= {r_message[8*MSG_BYTES-8:1], bus.in_data};
            r_byte_count <= w_count_nxt;
            if (w_end) begin
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_msg_valid <= 1'b1;
              // Only flag truncation when capacity was the sole reason to stop.
              r_truncated <= w_at_cap && !w_is_term && !bus.in_last;
            end
          end
        end

        S_DONE: begin
          // msg_ack wins over start; start alone is ignored here.
          if (bus.msg_ack) begin
            r_state     <= S_IDLE;
            r_msg_valid <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_msg_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.message    = r_message;
  assign bus.msg_valid  = r_msg_valid;
  assign bus.byte_count = r_byte_count;
  assign bus.truncated  = r_truncated;

endmodule

// File: tb/tb_message_byte_loader.sv
module tb_message_byte_loader;
  localparam int         MSG   = 100;
  localparam int         CNT_W = 7;
  localparam logic [7:0] TERM  = 8'h0A;
  localparam int         W     = 8 * MSG;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  message_byte_loader_if #(.MSG_BYTES(MSG), .CNT_W(CNT_W)) bus ();

  message_byte_loader #(.MSG_BYTES(MSG), .TERM_CHAR(TERM), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model results
  logic [W:1] exp_msg;
  int         exp_cnt;
  bit         exp_trunc;
  int         exp_end;

  // Reference: the message is the bytes up to the first end condition,
  // read as one big right-justified number.
  task automatic model_pack(input logic [7:0] b[$], input int last_idx);
    exp_end = -1;
    for (int i = 0; i < b.size(); i++) begin
      if (b[i] == TERM || i == last_idx || i == MSG - 1) begin
        exp_end = i;
        break;
      end
    end
    exp_msg = '0;
    for (int i = 0; i <= exp_end; i++)
      exp_msg = (exp_msg << 8) | {{(W-8){1'b0}}, b[i]};
    exp_cnt   = exp_end + 1;
    exp_trunc = (exp_end == MSG - 1) && (b[exp_end] != TERM) && (exp_end != last_idx);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // Presents bytes in order while the loader is in LOAD. gap_mode: 0 continuous,
  // 1 valid every other cycle, 2 random gaps. Returns at the negedge after the
  // loader leaves LOAD or the bytes run out.
  task automatic feed(input logic [7:0] b[$], input int last_idx, input int gap_mode,
                      output int n_acc, output int ready_cycles);
    int  cyc;
    bit  v;
    bit  acc;
    n_acc = 0;
    ready_cycles = 0;
    cyc = 0;
    while (n_acc < b.size() && bus.in_ready && cyc < 2000) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 1;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      bus.in_valid = v;
      bus.in_data  = b[n_acc];
      bus.in_last  = (n_acc == last_idx);
      if (bus.in_ready) ready_cycles++;
      acc = v && bus.in_ready;
      @(negedge clock);
      if (acc) n_acc++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    n_checks++;
    if (cyc >= 2000) begin
      n_fail++;
      $display("FAIL feed_timeout: cycles=%0d accepted=%0d limit=2000", cyc, n_acc);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.msg_valid !== 1'b0 || bus.truncated !== 1'b0 ||
        bus.byte_count !== '0 || bus.message !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b vld=%b trunc=%b cnt=%0d msg_nonzero=%b required all 0",
               bus.in_ready, bus.msg_valid, bus.truncated, bus.byte_count, |bus.message);
    end
    reset_n = 1'b1;
    @(negedge clock);
    bus.msg_ack = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h33;
    @(negedge clock);
    bus.msg_ack = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.msg_valid !== 1'b0 || bus.byte_count !== '0) begin
      n_fail++;
      $display("FAIL idle_ignores: rdy=%b vld=%b cnt=%0d required 0 0 0",
               bus.in_ready, bus.msg_valid, bus.byte_count);
    end
  endtask

  task automatic test_hi();
    logic [7:0] b[$];
    int n_acc, rc;
    b = '{8'h48, 8'h69, 8'h0A};
    model_pack(b, -1);
    pulse_start();
    feed(b, -1, 0, n_acc, rc);
    n_checks++;
    if (rc !== 3) begin
      n_fail++;
      $display("FAIL hi_ready_cycles: got %0d required 3", rc);
    end
    n_checks++;
    if (bus.msg_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hi_done_latency: vld=%b rdy=%b required 1 0", bus.msg_valid, bus.in_ready);
    end
    n_checks++;
    if (bus.message !== exp_msg || bus.message[24:1] !== 24'h48690A) begin
      n_fail++;
      $display("FAIL hi_message: got %h required %h", bus.message[32:1], exp_msg[32:1]);
    end
    n_checks++;
    if (bus.byte_count !== CNT_W'(3) || bus.truncated !== 1'b0) begin
      n_fail++;
      $display("FAIL hi_count_trunc: cnt=%0d trunc=%b required 3 0", bus.byte_count, bus.truncated);
    end
    bus.msg_ack = 1'b1;
    @(negedge clock);
    bus.msg_ack = 1'b0;
    n_checks++;
    if (bus.msg_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.message !== exp_msg) begin
      n_fail++;
      $display("FAIL hi_ack: vld=%b rdy=%b msg_held=%b required 0 0 1",
               bus.msg_valid, bus.in_ready, bus.message === exp_msg);
    end
  endtask

  task automatic test_capacity();
    logic [7:0] b[$];
    int n_acc, rc;
    for (int pass = 0; pass < 2; pass++) begin
      b.delete();
      for (int i = 0; i < MSG; i++) b.push_back(8'h41);
      if (pass == 1) b[MSG-1] = TERM;
      model_pack(b, -1);
      pulse_start();
      feed(b, -1, 0, n_acc, rc);
      n_checks++;
      if (bus.msg_valid !== 1'b1 || bus.in_ready !== 1'b0 || n_acc !== MSG) begin
        n_fail++;
        $display("FAIL cap%0d_done: vld=%b rdy=%b acc=%0d required 1 0 %0d",
                 pass, bus.msg_valid, bus.in_ready, n_acc, MSG);
      end
      n_checks++;
      if (bus.message !== exp_msg) begin
        n_fail++;
        $display("FAIL cap%0d_message: got %h required %h", pass, bus.message, exp_msg);
      end
      n_checks++;
      if (bus.byte_count !== CNT_W'(MSG) || bus.truncated !== (pass == 0)) begin
        n_fail++;
        $display("FAIL cap%0d_count_trunc: cnt=%0d trunc=%b required %0d %b",
                 pass, bus.byte_count, bus.truncated, MSG, pass == 0);
      end
      bus.msg_ack = 1'b1;
      @(negedge clock);
      bus.msg_ack = 1'b0;
    end
  endtask

  task automatic test_gaps_last();
    logic [7:0] b[$];
    int n_acc, rc;
    b = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    model_pack(b, 4);
    pulse_start();
    feed(b, 4, 1, n_acc, rc);
    n_checks++;
    if (bus.message !== exp_msg || bus.message[40:1] !== 40'h68656C6C6F) begin
      n_fail++;
      $display("FAIL hello_message: got %h required %h", bus.message[48:1], exp_msg[48:1]);
    end
    n_checks++;
    if (bus.byte_count !== CNT_W'(5) || bus.truncated !== 1'b0 || bus.msg_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hello_state: cnt=%0d trunc=%b vld=%b required 5 0 1",
               bus.byte_count, bus.truncated, bus.msg_valid);
    end
    bus.msg_ack = 1'b1;
    @(negedge clock);
    bus.msg_ack = 1'b0;
  endtask

  task automatic test_start_in_load();
    logic [7:0] b[$];
    logic [7:0] c[$];
    int n_acc, rc;
    b = '{8'h11, 8'h22};
    pulse_start();
    feed(b, -1, 0, n_acc, rc);
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h99;
    @(negedge clock);
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.byte_count !== '0 || bus.message !== '0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clear: cnt=%0d msg_nonzero=%b rdy=%b required 0 0 1",
               bus.byte_count, |bus.message, bus.in_ready);
    end
    c = '{8'h61, 8'h62, 8'h0A};
    model_pack(c, -1);
    feed(c, -1, 2, n_acc, rc);
    n_checks++;
    if (bus.message !== exp_msg || bus.byte_count !== CNT_W'(exp_cnt)) begin
      n_fail++;
      $display("FAIL restart_repack: got %h cnt=%0d required %h cnt=%0d",
               bus.message[32:1], bus.byte_count, exp_msg[32:1], exp_cnt);
    end
    bus.msg_ack = 1'b1;
    @(negedge clock);
    bus.msg_ack = 1'b0;
  endtask

  task automatic test_reset_in_load();
    logic [7:0] b[$];
    int n_acc, rc;
    bit bad;
    b = '{8'h55, 8'h66};
    pulse_start();
    feed(b, -1, 0, n_acc, rc);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.msg_valid !== 1'b0 || bus.byte_count !== '0 ||
        bus.message !== '0 || bus.truncated !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b vld=%b cnt=%0d msg_nonzero=%b trunc=%b required all 0",
               bus.in_ready, bus.msg_valid, bus.byte_count, |bus.message, bus.truncated);
    end
    @(negedge clock);
    reset_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h77;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (bus.in_ready !== 1'b0 || bus.byte_count !== '0) bad = 1'b1;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL post_reset_idle: rdy=%b cnt=%0d required 0 0", bus.in_ready, bus.byte_count);
    end
  endtask

  task automatic test_done_hold();
    logic [7:0] b[$];
    int n_acc, rc;
    b = '{8'h31, 8'h32, 8'h33, 8'h0A};
    model_pack(b, -1);
    pulse_start();
    feed(b, -1, 0, n_acc, rc);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h7E;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.msg_valid !== 1'b1 || bus.message !== exp_msg ||
        bus.byte_count !== CNT_W'(exp_cnt)) begin
      n_fail++;
      $display("FAIL done_hold: rdy=%b vld=%b cnt=%0d msg_ok=%b required 0 1 %0d 1",
               bus.in_ready, bus.msg_valid, bus.byte_count, bus.message === exp_msg, exp_cnt);
    end
    bus.msg_ack = 1'b1;
    bus.start = 1'b1;
    @(negedge clock);
    bus.msg_ack = 1'b0;
    bus.start = 1'b0;
    @(negedge clock);
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.msg_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.message !== exp_msg ||
        bus.byte_count !== CNT_W'(exp_cnt)) begin
      n_fail++;
      $display("FAIL ack_beats_start: vld=%b rdy=%b cnt=%0d msg_ok=%b required 0 0 %0d 1",
               bus.msg_valid, bus.in_ready, bus.byte_count, bus.message === exp_msg, exp_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] b[$];
    int n_acc, rc, mode, p, last_idx;
    for (int it = 0; it < 20; it++) begin
      b.delete();
      for (int i = 0; i < 130; i++) begin
        logic [7:0] x;
        x = 8'($urandom);
        if (x == TERM) x = 8'h20;
        b.push_back(x);
      end
      mode = $urandom_range(0, 2);
      p = $urandom_range(0, 119);
      last_idx = -1;
      if (mode == 0) b[p] = TERM;
      else if (mode == 1) last_idx = p;
      model_pack(b, last_idx);
      pulse_start();
      feed(b, last_idx, 2, n_acc, rc);
      n_checks++;
      if (bus.msg_valid !== 1'b1 || bus.message !== exp_msg ||
          bus.byte_count !== CNT_W'(exp_cnt) || bus.truncated !== exp_trunc) begin
        n_fail++;
        $display("FAIL random_%0d: vld=%b cnt=%0d trunc=%b msg_ok=%b required 1 %0d %b 1",
                 it, bus.msg_valid, bus.byte_count, bus.truncated, bus.message === exp_msg,
                 exp_cnt, exp_trunc);
      end
      repeat ($urandom_range(0, 3)) @(negedge clock);
      bus.msg_ack = 1'b1;
      @(negedge clock);
      bus.msg_ack = 1'b0;
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    bus.msg_ack  = 1'b0;
    test_reset();
    test_hi();
    test_capacity();
    test_gaps_last();
    test_start_in_load();
    test_reset_in_load();
    test_done_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
